// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_timer
// Description : Loadable down-counter/timer with one-shot and auto-reload
//               modes. Flags terminal count with a single-cycle Done pulse.
//               This is the count-down counterpart of the synchronous
//               up-counter and serves as a timeout/interval generator.
//
// Ports       :
//   Clk        in   system clock, rising-edge active
//   Reset      in   asynchronous active-high reset
//   Load       in   capture LoadValue and (re)start counting; top priority
//   LoadValue  in   start/reload value (unsigned, CNT_WIDTH bits)
//   CountEn    in   decrement enable; low holds the count
//   AutoReload in   1 = periodic, 0 = one-shot; sampled at each terminal step
//   CounterOut out  current count (registered)
//   Done       out  one-cycle terminal-count pulse (registered)
//   Busy       out  high while the timer is in RUN (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Load,
    input  logic [CNT_WIDTH-1:0] LoadValue,
    input  logic                 CountEn,
    input  logic                 AutoReload,
    output logic [CNT_WIDTH-1:0] CounterOut,
    output logic                 Done,
    output logic                 Busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] C_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q,  state_d;
    logic [CNT_WIDTH-1:0]   count_q,  count_d;
    logic [CNT_WIDTH-1:0]   reload_q, reload_d;
    logic                   done_q,   done_d;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            count_q  <= C_ZERO;
            reload_q <= C_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Done defaults low so the pulse is exactly one cycle
    // wide whatever CountEn does on the following edge.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (Load) begin
            // Load beats everything, including a coincident terminal step.
            count_d  = LoadValue;
            reload_d = LoadValue;
            state_d  = (LoadValue != C_ZERO) ? ST_RUN : ST_IDLE;
        end else if (state_q == ST_RUN && CountEn) begin
            if (count_q > C_ONE) begin
                count_d = count_q - C_ONE;
            end else if (count_q == C_ONE) begin
                done_d = 1'b1;
                if (AutoReload) begin
                    count_d = reload_q;
                end else begin
                    count_d = C_ZERO;
                    state_d = ST_IDLE;
                end
            end else begin
                // Zero while running is unreachable; park safely, never wrap.
                state_d = ST_IDLE;
            end
        end
    end

    assign CounterOut = count_q;
    assign Done       = done_q;
    assign Busy       = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter_timer
// Description : Directed self-checking bench for down_counter_timer
//               (CNT_WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_timer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load;
    logic [3:0] LoadValue;
    logic       CountEn;
    logic       AutoReload;
    logic [3:0] CounterOut;
    logic       Done;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    down_counter_timer #(.CNT_WIDTH(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load       (Load),
        .LoadValue  (LoadValue),
        .CountEn    (CountEn),
        .AutoReload (AutoReload),
        .CounterOut (CounterOut),
        .Done       (Done),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Load = 1'b0; LoadValue = 4'd0; CountEn = 1'b0; AutoReload = 1'b0;
        tick(); tick();
        total++;
        if (CounterOut !== 4'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: out=%0d done=%b busy=%b expected out=0 done=0 busy=0", CounterOut, Done, Busy);
        end
        Reset = 1'b0;
        // Load 5, count down to 3, then reset asynchronously between edges.
        Load = 1'b1; LoadValue = 4'd5;
        tick();
        Load = 1'b0; CountEn = 1'b1;
        tick(); tick();
        total++;
        if (CounterOut !== 4'd3 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_precount: out=%0d busy=%b expected out=3 busy=1", CounterOut, Busy);
        end
        #3;
        Reset = 1'b1;
        #1;
        total++;
        if (CounterOut !== 4'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: out=%0d done=%b busy=%b expected out=0 done=0 busy=0", CounterOut, Done, Busy);
        end
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (CounterOut !== 4'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_after[%0d]: out=%0d done=%b busy=%b expected out=0 done=0 busy=0", i, CounterOut, Done, Busy);
            end
        end
        CountEn = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_out [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        AutoReload = 1'b0; CountEn = 1'b1;
        Load = 1'b1; LoadValue = 4'd5;
        tick();
        total++;
        if (CounterOut !== 4'd5 || Done !== 1'b0 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_load: out=%0d done=%b busy=%b expected out=5 done=0 busy=1", CounterOut, Done, Busy);
        end
        Load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (CounterOut !== exp_out[i] || Done !== (i == 4) || Busy !== (i != 4)) begin
                bad++;
                $display("FAIL oneshot_step[%0d]: out=%0d done=%b busy=%b expected out=%0d done=%b busy=%b",
                         i, CounterOut, Done, Busy, exp_out[i], (i == 4), (i != 4));
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (CounterOut !== 4'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
                bad++;
                $display("FAIL oneshot_hold[%0d]: out=%0d done=%b busy=%b expected out=0 done=0 busy=0", i, CounterOut, Done, Busy);
            end
        end
        CountEn = 1'b0;
    endtask

    task automatic test_autoreload();
        logic [3:0] exp;
        logic       exp_done;
        int         pulses;
        pulses = 0;
        AutoReload = 1'b1; CountEn = 1'b1;
        Load = 1'b1; LoadValue = 4'd3;
        tick();
        Load = 1'b0;
        exp = 4'd3;
        for (int i = 0; i < 12; i++) begin
            exp_done = (exp == 4'd1);
            exp      = (exp == 4'd1) ? 4'd3 : exp - 4'd1;
            tick();
            if (Done === 1'b1) pulses++;
            total++;
            if (CounterOut !== exp || Done !== exp_done || Busy !== 1'b1) begin
                bad++;
                $display("FAIL autoreload_step[%0d]: out=%0d done=%b busy=%b expected out=%0d done=%b busy=1",
                         i, CounterOut, Done, Busy, exp, exp_done);
            end
        end
        total++;
        if (pulses !== 4) begin
            bad++;
            $display("FAIL autoreload_pulses: got %0d expected 4", pulses);
        end
        // Now at 3: step to 2, then switch to one-shot; next terminal step stops.
        tick();
        AutoReload = 1'b0;
        tick();
        tick();
        total++;
        if (CounterOut !== 4'd0 || Done !== 1'b1 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL autoreload_switch: out=%0d done=%b busy=%b expected out=0 done=1 busy=0", CounterOut, Done, Busy);
        end
        CountEn = 1'b0;
    endtask

    task automatic test_gaps();
        logic       en_pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_out [7] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0};
        AutoReload = 1'b0; CountEn = 1'b0;
        Load = 1'b1; LoadValue = 4'd4;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            CountEn = en_pat[i];
            tick();
            total++;
            if (CounterOut !== exp_out[i] || Done !== (i == 6)) begin
                bad++;
                $display("FAIL gaps_step[%0d]: out=%0d done=%b expected out=%0d done=%b",
                         i, CounterOut, Done, exp_out[i], (i == 6));
            end
        end
        CountEn = 1'b0;
    endtask

    task automatic test_back_to_back();
        AutoReload = 1'b0; CountEn = 1'b0;
        Load = 1'b1; LoadValue = 4'd2;
        tick();
        Load = 1'b0; CountEn = 1'b1;
        tick();
        total++;
        if (CounterOut !== 4'd1) begin
            bad++;
            $display("FAIL collision_pre: out=%0d expected 1", CounterOut);
        end
        Load = 1'b1; LoadValue = 4'd9;
        tick();
        total++;
        if (CounterOut !== 4'd9 || Done !== 1'b0 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL collision: out=%0d done=%b busy=%b expected out=9 done=0 busy=1", CounterOut, Done, Busy);
        end
        Load = 1'b0;
        tick();
        total++;
        if (CounterOut !== 4'd8 || Done !== 1'b0) begin
            bad++;
            $display("FAIL collision_post: out=%0d done=%b expected out=8 done=0", CounterOut, Done);
        end
        CountEn = 1'b0;
    endtask

    task automatic test_edge_values();
        AutoReload = 1'b0; CountEn = 1'b1;
        Load = 1'b1; LoadValue = 4'd0;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (CounterOut !== 4'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
                bad++;
                $display("FAIL load_zero[%0d]: out=%0d done=%b busy=%b expected out=0 done=0 busy=0", i, CounterOut, Done, Busy);
            end
            tick();
        end
        Load = 1'b1; LoadValue = 4'd15;
        tick();
        Load = 1'b0;
        total++;
        if (CounterOut !== 4'd15 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL load_max: out=%0d busy=%b expected out=15 busy=1", CounterOut, Busy);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            total++;
            if (CounterOut !== 4'(15 - i) || Done !== (i == 15)) begin
                bad++;
                $display("FAIL max_step[%0d]: out=%0d done=%b expected out=%0d done=%b",
                         i, CounterOut, Done, 15 - i, (i == 15));
            end
        end
        tick();
        total++;
        if (CounterOut !== 4'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL max_after: out=%0d done=%b busy=%b expected out=0 done=0 busy=0", CounterOut, Done, Busy);
        end
        CountEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_gaps();
        test_back_to_back();
        test_edge_values();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
